imem_loader: RTL and testbench

Byte-stream instruction-memory writer for the mips32 core; it supplies the "code" mode that fills the instruction memory read by the fetch stage. It accepts framed bytes over a valid/ready link (UART RX or bench), packs them into 32-bit words, and issues single-cycle word writes to the instruction-memory write port. While a frame is in progress it holds the core in reset through `cpu_hold`.

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader_byte_packer.sv | 69 ++++++
 rtl/imem_loader.sv | 207 ++++++++++++++++++++
 tb/tb_imem_loader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared states and constants for the instruction-memory loader
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_WRITE,
        ST_CSUM,
        ST_DONE
    } ldr_state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    localparam int         HDR_BYTES    = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - packs bytes MSB-first into 32-bit words
// Running-XOR checksum accumulator exists only when IMEM_LOADER_CSUM_EN is defined.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
`ifdef IMEM_LOADER_CSUM_EN
    input  logic        acc_en,
    output logic [7:0]  csum,
`endif
    output logic [31:0] word,
    output logic        word_full
);

    logic [31:0] word_q, word_d;
    logic [1:0]  idx_q, idx_d;

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (clr) begin
            word_d = '0;
            idx_d  = '0;
        end else if (shift_en) begin
            word_d = {word_q[23:0], byte_in};
            idx_d  = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

    assign word = word_q;
    // Three bytes held: the next shift completes the word.
    assign word_full = (idx_q == 2'd3);

`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (clr) begin
            csum_d = '0;
        end else if (acc_en) begin
            csum_d = csum_q ^ byte_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign csum = csum_q;
`endif

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte stream to instruction-memory word writes, holds the core while loading
// Optional trailing checksum byte enabled by defining IMEM_LOADER_CSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         AW   = 10,
    parameter logic [7:0] SYNC = SYNC_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          cpu_hold,
    output logic          done,
    output logic          err
);

    ldr_state_t    state_q, state_d;
    logic [1:0]    hdr_idx_q, hdr_idx_d;
    logic [7:0]    hdr_hi_q, hdr_hi_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          we_q, we_d;
    logic          done_q, done_d;
    logic          hold_q, hold_d;

    logic          xfer;
    logic          finish;
    logic [15:0]   hdr_word;
    logic          pk_clr, pk_shift;
    logic [31:0]   pk_word;
    logic          pk_full;

`ifdef IMEM_LOADER_CSUM_EN
    logic          err_q, err_d;
    logic          pk_acc;
    logic [7:0]    pk_csum;
`endif

    assign xfer     = in_valid && in_ready;
    assign hdr_word = {hdr_hi_q, in_data};

    always_comb begin
        state_d   = state_q;
        hdr_idx_d = hdr_idx_q;
        hdr_hi_d  = hdr_hi_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        we_d      = 1'b0;
        done_d    = 1'b0;
        hold_d    = hold_q;
        finish    = 1'b0;
        pk_clr    = 1'b0;
        pk_shift  = 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
        err_d     = err_q;
        pk_acc    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (xfer && in_data == SYNC) begin
                    state_d   = ST_HDR;
                    hdr_idx_d = '0;
                    hold_d    = 1'b1;
                    pk_clr    = 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
                    err_d     = 1'b0;
`endif
                end
            end
            ST_HDR: begin
                if (xfer) begin
`ifdef IMEM_LOADER_CSUM_EN
                    pk_acc    = 1'b1;
`endif
                    hdr_idx_d = hdr_idx_q + 2'd1;
                    hdr_hi_d  = in_data;
                    if (hdr_idx_q == 2'd1) begin
                        addr_d = hdr_word[AW-1:0];
                    end
                    if (hdr_idx_q == 2'(HDR_BYTES - 1)) begin
                        cnt_d = hdr_word;
                        if (hdr_word == 16'd0) begin
                            finish = 1'b1;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    pk_shift = 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
                    pk_acc   = 1'b1;
`endif
                    if (pk_full) begin
                        state_d = ST_WRITE;
                        we_d    = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                addr_d = addr_q + 1'b1;
                cnt_d  = cnt_q - 16'd1;
                if (cnt_q != 16'd1) begin
                    state_d = ST_DATA;
                end else begin
                    finish = 1'b1;
                end
            end
`ifdef IMEM_LOADER_CSUM_EN
            ST_CSUM: begin
                if (xfer) begin
                    if (in_data != pk_csum) begin
                        err_d = 1'b1;
                    end
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    hold_d  = 1'b0;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // End of payload: either collect the checksum byte or close the frame now.
        if (finish) begin
`ifdef IMEM_LOADER_CSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            hdr_idx_q <= '0;
            hdr_hi_q  <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            hold_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_idx_q <= hdr_idx_d;
            hdr_hi_q  <= hdr_hi_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            done_q    <= done_d;
            hold_q    <= hold_d;
        end
    end

`ifdef IMEM_LOADER_CSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (pk_clr),
        .shift_en  (pk_shift),
        .byte_in   (in_data),
`ifdef IMEM_LOADER_CSUM_EN
        .acc_en    (pk_acc),
        .csum      (pk_csum),
`endif
        .word      (pk_word),
        .word_full (pk_full)
    );

    // Held low while in reset so no byte is taken before IDLE is live.
    assign in_ready = ~rst && (state_q == ST_IDLE || state_q == ST_HDR ||
                               state_q == ST_DATA || state_q == ST_CSUM);

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = pk_word;
    assign cpu_hold   = hold_q;
    assign done       = done_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader (frame table, directed corners, random frames)
module tb_imem_loader;

    localparam int AW = 10;
`ifdef IMEM_LOADER_CSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    imem_loader #(.AW(AW), .SYNC(8'hA5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    int total = 0;
    int bad   = 0;

    // Observed write-port and done activity, recorded away from the clock edge.
    logic [AW-1:0] got_addr[$];
    logic [31:0]   got_data[$];
    int            done_cnt = 0;
    int            hold_at_done = 0;

    always @(negedge clk) begin
        if (imem_we) begin
            got_addr.push_back(imem_addr);
            got_data.push_back(imem_wdata);
        end
        if (done) begin
            done_cnt++;
            if (cpu_hold) hold_at_done++;
        end
    end

    // Reference: expected (address, word) pairs for the frame in flight.
    logic [AW-1:0] exp_addr[$];
    logic [31:0]   exp_data[$];
    int            rd_idx = 0;
    logic [31:0]   words[0:63];
    logic [7:0]    tb_csum = 8'h00;

    typedef struct {
        logic [15:0]   addr;
        logic [15:0]   cnt;
        logic [31:0]   w0;
        logic [31:0]   w1;
        logic          bad_cs;
        int            exp_writes;
        logic [AW-1:0] exp_first;
        logic [AW-1:0] exp_last;
    } frame_vec_t;

    frame_vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int pick_gap(input int maxgap);
        return int'($urandom_range(maxgap, 0));
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        @(negedge clk);
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_wait", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        tb_csum  = tb_csum ^ b;
    endtask

    task automatic model_frame(input logic [15:0] a, input int c);
        for (int i = 0; i < c; i++) begin
            exp_addr.push_back(AW'((int'(a) + i) % (1 << AW)));
            exp_data.push_back(words[i]);
        end
    endtask

    task automatic start_frame(input logic [15:0] a, input logic [15:0] c, input int maxgap);
        send_byte(8'hA5, pick_gap(maxgap));
        @(negedge clk);
        check("hold_after_sync", 32'(cpu_hold), 32'd1);
        check("err_clear_on_sync", 32'(err), 32'd0);
        tb_csum = 8'h00;
        send_byte(a[15:8], pick_gap(maxgap));
        send_byte(a[7:0],  pick_gap(maxgap));
        send_byte(c[15:8], pick_gap(maxgap));
        send_byte(c[7:0],  pick_gap(maxgap));
    endtask

    task automatic send_data(input int c, input int maxgap);
        logic [7:0] b;
        for (int i = 0; i < c; i++) begin
            for (int k = 3; k >= 0; k--) begin
                b = words[i][8*k +: 8];
                send_byte(b, pick_gap(maxgap));
            end
        end
    endtask

    task automatic finish_frame(input int d0, input logic bad_cs);
        int n;
        int ng;
        logic [7:0] cs;
        cs = tb_csum ^ (bad_cs ? 8'h5A : 8'h00);
`ifdef IMEM_LOADER_CSUM_EN
        send_byte(cs, 0);
`endif
        n = 0;
        while (done_cnt == d0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("done_pulse_count", 32'(done_cnt - d0), 32'd1);
        check("hold_released", 32'(cpu_hold), 32'd0);
        check("err_flag", 32'(err), 32'(CSUM_ON & bad_cs));
        ng = got_addr.size() - rd_idx;
        check("write_count", 32'(ng), 32'(exp_addr.size()));
        for (int i = 0; i < ng && i < exp_addr.size(); i++) begin
            check("write_addr", 32'(got_addr[rd_idx + i]), 32'(exp_addr[i]));
            check("write_data", got_data[rd_idx + i], exp_data[i]);
        end
        rd_idx = got_addr.size();
        exp_addr.delete();
        exp_data.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0;
        int g0;
        logic [15:0] ra;
        int rc;
        logic rb;

        vecs[0] = '{16'h0005, 16'd2, 32'h12345678, 32'hDEADBEEF, 1'b0, 2, 10'd5,    10'd6};
        vecs[1] = '{16'h03FF, 16'd2, 32'hCAFEF00D, 32'hA5A5A5A5, 1'b0, 2, 10'd1023, 10'd0};
        vecs[2] = '{16'h0005, 16'd0, 32'h00000000, 32'h00000000, 1'b0, 0, 10'd0,    10'd0};
        vecs[3] = '{16'hFC10, 16'd1, 32'h01020304, 32'h00000000, 1'b1, 1, 10'h010,  10'h010};
        vecs[4] = '{16'h0100, 16'd1, 32'hA5000000, 32'h00000000, 1'b0, 1, 10'h100,  10'h100};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_imem_wdata", imem_wdata, 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Non-SYNC bytes in IDLE are dropped.
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        @(negedge clk);
        check("drop_no_write", 32'(got_addr.size()), 32'd0);
        check("drop_no_hold", 32'(cpu_hold), 32'd0);
        check("drop_no_done", 32'(done_cnt), 32'd0);

        // Frame table.
        for (int v = 0; v < 5; v++) begin
            words[0] = vecs[v].w0;
            words[1] = vecs[v].w1;
            d0 = done_cnt;
            g0 = got_addr.size();
            model_frame(vecs[v].addr, int'(vecs[v].cnt));
            start_frame(vecs[v].addr, vecs[v].cnt, 0);
            send_data(int'(vecs[v].cnt), 0);
            finish_frame(d0, vecs[v].bad_cs);
            check("vec_writes", 32'(got_addr.size() - g0), 32'(vecs[v].exp_writes));
            if (vecs[v].exp_writes > 0 && got_addr.size() >= g0 + vecs[v].exp_writes) begin
                check("vec_first_addr", 32'(got_addr[g0]), 32'(vecs[v].exp_first));
                check("vec_last_addr", 32'(got_addr[g0 + vecs[v].exp_writes - 1]), 32'(vecs[v].exp_last));
            end
        end

        // Reset after the second data byte of a word.
        words[0] = 32'h11223344;
        d0 = done_cnt;
        g0 = got_addr.size();
        start_frame(16'h0010, 16'd2, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_hold", 32'(cpu_hold), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_we", 32'(imem_we), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_idle", 32'(in_ready), 32'd1);
        check("midrst_no_write", 32'(got_addr.size() - g0), 32'd0);
        check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        rd_idx = got_addr.size();

        // Stall mid-word: the write comes one cycle after the 4th byte, whenever that arrives.
        words[0] = 32'h0BADC0DE;
        d0 = done_cnt;
        model_frame(16'h0020, 1);
        start_frame(16'h0020, 16'd1, 0);
        send_byte(8'h0B, 0);
        send_byte(8'hAD, 0);
        send_byte(8'hC0, 0);
        g0 = got_addr.size();
        repeat (4) @(negedge clk);
        check("stall_no_write", 32'(got_addr.size() - g0), 32'd0);
        check("stall_hold", 32'(cpu_hold), 32'd1);
        send_byte(8'hDE, 0);
        @(negedge clk);
        check("lat_we", 32'(imem_we), 32'd1);
        check("lat_in_ready", 32'(in_ready), 32'd0);
        check("lat_addr", 32'(imem_addr), 32'h20);
        check("lat_wdata", imem_wdata, 32'h0BADC0DE);
        finish_frame(d0, 1'b0);

        // Random frames with random gaps.
        for (int f = 0; f < 20; f++) begin
            ra = 16'($urandom);
            rc = int'($urandom_range(5, 1));
            rb = 1'($urandom_range(1, 0));
            for (int i = 0; i < rc; i++) words[i] = $urandom;
            d0 = done_cnt;
            model_frame(ra, rc);
            start_frame(ra, 16'(rc), 2);
            send_data(rc, 2);
            finish_frame(d0, rb);
        end

        check("hold_low_at_done", 32'(hold_at_done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
